// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   muldiv_mode_e : operation codes from the decoder (4-bit MULDIVMode field)
//   MULDIV_HIGH/LOW : HILOSel values selecting HI or LO onto MULDIVOut
//   state_e       : FSM state codes of muldiv_unit
//   is_arith_op   : true for operations that occupy the unit for several cycles
//   is_mult_op    : true for the multiply flavours (selects the busy length)
package muldiv_unit_pkg;

  typedef enum logic [3:0] {
    MULDIV_NOTHING = 4'd0,
    MULDIV_MULT    = 4'd1,
    MULDIV_MULTU   = 4'd2,
    MULDIV_DIV     = 4'd3,
    MULDIV_DIVU    = 4'd4,
    MULDIV_MTHI    = 4'd5,
    MULDIV_MTLO    = 4'd6
  } muldiv_mode_e;

  localparam logic MULDIV_HIGH = 1'b1;
  localparam logic MULDIV_LOW  = 1'b0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  function automatic logic is_arith_op(input logic [3:0] mode);
    return (mode == MULDIV_MULT) || (mode == MULDIV_MULTU) ||
           (mode == MULDIV_DIV)  || (mode == MULDIV_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [3:0] mode);
    return (mode == MULDIV_MULT) || (mode == MULDIV_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Purely combinational arithmetic core of the multiply/divide unit.
// Ports:
//   mode        in   4   operation code (muldiv_mode_e)
//   a, b        in   32  operands (a = rs, b = rt)
//   result      out  64  {hi, lo}: product, or {remainder, quotient}
//   div_by_zero out  1   divide requested with b == 0 (result is then 0)
module muldiv_calc
  import muldiv_unit_pkg::*;
(
  input  logic [3:0]  mode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] a_s64;
  logic signed [63:0] b_s64;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_b;
  logic signed [31:0] a_s;
  logic signed [31:0] div_b_s;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  // Signed operands widen with sign extension before multiplying.
  assign a_s    = a;
  assign a_s64  = a_s;
  assign b_s64  = $signed(b);
  assign prod_s = a_s64 * b_s64;
  assign prod_u = {32'h0, a} * {32'h0, b};

  // Divisor forced non-zero so the dividers never see 0; the flag below
  // suppresses the write-back instead.
  assign div_b   = (b == 32'h0) ? 32'h1 : b;
  assign div_b_s = div_b;
  assign quot_s  = a_s / div_b_s;
  assign rem_s   = a_s % div_b_s;
  assign quot_u  = a / div_b;
  assign rem_u   = a % div_b;

  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    case (mode)
      MULDIV_MULT:  result = prod_s;
      MULDIV_MULTU: result = prod_u;
      MULDIV_DIV: begin
        if (b == 32'h0) begin
          div_by_zero = 1'b1;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          // Only overflowing case: quotient wraps to the dividend, remainder 0.
          result = {32'h0, 32'h8000_0000};
        end else begin
          result = {rem_s, quot_s};
        end
      end
      MULDIV_DIVU: begin
        if (b == 32'h0) begin
          div_by_zero = 1'b1;
        end else begin
          result = {rem_u, quot_u};
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-high reset, clears all state
//   MULDIVMode in   4   operation from decoder (muldiv_mode_e)
//   A, B       in   32  forwarded rs / rt operands
//   HILOSel    in   1   MULDIV_HIGH selects HI, MULDIV_LOW selects LO
//   Start      out  1   arithmetic op presented while not busy (combinational)
//   Busy       out  1   registered, high while an operation is in flight
//   MULDIVOut  out  32  current architectural HI or LO
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MULDIVMode,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HILOSel,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] MULDIVOut
);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_tmp_q, hi_tmp_d;
  logic [31:0] lo_tmp_q, lo_tmp_d;
  logic        dz_q, dz_d;

  logic [63:0] calc_result;
  logic        calc_dz;

  muldiv_calc u_calc (
    .mode        (MULDIVMode),
    .a           (A),
    .b           (B),
    .result      (calc_result),
    .div_by_zero (calc_dz)
  );

  assign Start = is_arith_op(MULDIVMode) && !busy_q;
  assign Busy  = busy_q;

  // Only the architectural registers are visible; pending results stay hidden.
  always_comb begin
    MULDIVOut = lo_q;
    case (HILOSel)
      MULDIV_HIGH: MULDIVOut = hi_q;
      MULDIV_LOW:  MULDIVOut = lo_q;
      default:     MULDIVOut = lo_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          // Operands are captured here only; A/B may change freely afterwards.
          {hi_tmp_d, lo_tmp_d} = calc_result;
          dz_d    = calc_dz;
          cnt_d   = is_mult_op(MULDIVMode) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          busy_d  = 1'b1;
          state_d = S_BUSY;
        end else if (MULDIVMode == MULDIV_MTHI) begin
          hi_d = A;
        end else if (MULDIVMode == MULDIV_MTLO) begin
          lo_d = A;
        end
      end
      S_BUSY: begin
        // Any mode presented while busy is ignored.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (!dz_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= 4'd0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
      hi_tmp_q <= 32'h0;
      lo_tmp_q <= 32'h0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected Start/Busy/
// MULDIVOut values per probed cycle, a monitor pops and compares them.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  MULDIVMode = 4'd0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic        HILOSel = 1'b0;
  logic        Start;
  logic        Busy;
  logic [31:0] MULDIVOut;

  always #5 clk = ~clk;

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .MULDIVMode (MULDIVMode),
    .A          (A),
    .B          (B),
    .HILOSel    (HILOSel),
    .Start      (Start),
    .Busy       (Busy),
    .MULDIVOut  (MULDIVOut)
  );

  typedef struct {
    string       name;
    bit          co;
    logic [31:0] eo;
    bit          cs;
    logic        es;
    bit          cb;
    logic        eb;
  } exp_t;

  exp_t sb_q[$];
  logic probe = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checks++;
      if (Start && Busy) begin
        errors++;
        $display("FAIL start_while_busy: Start=%0b Busy=%0b, required Start=0 while Busy", Start, Busy);
      end
    end
    if (probe) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: probe with no expected entry, required an entry");
      end else begin
        e = sb_q.pop_front();
        $display("txn %-16s out=%08h start=%0b busy=%0b", e.name, MULDIVOut, Start, Busy);
        if (e.co) begin
          checks++;
          if (MULDIVOut !== e.eo) begin
            errors++;
            $display("FAIL %s out: got %08h required %08h", e.name, MULDIVOut, e.eo);
          end
        end
        if (e.cs) begin
          checks++;
          if (Start !== e.es) begin
            errors++;
            $display("FAIL %s start: got %0b required %0b", e.name, Start, e.es);
          end
        end
        if (e.cb) begin
          checks++;
          if (Busy !== e.eb) begin
            errors++;
            $display("FAIL %s busy: got %0b required %0b", e.name, Busy, e.eb);
          end
        end
      end
    end
  end

  // One clock of stimulus: drive 1 ns after the rising edge, optionally queue checks.
  task automatic step(input logic r, input logic [3:0] m, input logic [31:0] a,
                      input logic [31:0] b, input logic s, input string nm,
                      input bit co, input logic [31:0] eo, input bit cs,
                      input logic es, input bit cb, input logic eb);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = r;
    MULDIVMode = m;
    A          = a;
    B          = b;
    HILOSel    = s;
    if (co || cs || cb) begin
      e = '{name: nm, co: co, eo: eo, cs: cs, es: es, cb: cb, eb: eb};
      sb_q.push_back(e);
      probe = 1'b1;
    end else begin
      probe = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, MULDIV_NOTHING, 32'h0, 32'h0, 1'b0, "idle", 0, 32'h0, 0, 1'b0, 0, 1'b0);
  endtask

  // Idle-cycle read of HI (sel=1) or LO (sel=0), Busy and Start expected low.
  task automatic rd(input logic sel, input logic [31:0] exp_v, input string nm);
    step(1'b0, MULDIV_NOTHING, 32'h0, 32'h0, sel, nm, 1, exp_v, 1, 1'b0, 1, 1'b0);
  endtask

  // Issue an arithmetic op and follow it through n busy cycles, holding
  // hold_m on the mode input and scrambling A/B. HI must stay at busy_hi.
  task automatic run_op(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [3:0] hold_m,
                        input logic [31:0] busy_hi, input string nm);
    step(1'b0, m, a, b, 1'b1, {nm, "_start"}, 1, busy_hi, 1, 1'b1, 1, 1'b0);
    for (int i = 0; i < n; i++)
      step(1'b0, hold_m, $urandom, $urandom, 1'b1, {nm, "_busy"}, 1, busy_hi, 1, 1'b0, 1, 1'b1);
  endtask

  initial begin
    // Reset state; Start still follows the mode while reset is held.
    step(1'b1, MULDIV_MULT, 32'h5, 32'h6, 1'b1, "rst_hi", 1, 32'h0, 1, 1'b1, 1, 1'b0);
    step(1'b1, MULDIV_NOTHING, 32'h0, 32'h0, 1'b0, "rst_lo", 1, 32'h0, 1, 1'b0, 1, 1'b0);
    idle(2);

    // MULT -2 * 3
    run_op(MULDIV_MULT, 32'hFFFF_FFFE, 32'h3, 5, MULDIV_NOTHING, 32'h0, "mult");
    rd(1'b1, 32'hFFFF_FFFF, "mult_hi");
    rd(1'b0, 32'hFFFF_FFFA, "mult_lo");

    // MULTU max * max
    run_op(MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, MULDIV_NOTHING, 32'hFFFF_FFFF, "multu");
    rd(1'b1, 32'hFFFF_FFFE, "multu_hi");
    rd(1'b0, 32'h0000_0001, "multu_lo");

    // DIV -7 / 2
    run_op(MULDIV_DIV, 32'hFFFF_FFF9, 32'h2, 10, MULDIV_NOTHING, 32'hFFFF_FFFE, "div");
    rd(1'b1, 32'hFFFF_FFFF, "div_hi");
    rd(1'b0, 32'hFFFF_FFFD, "div_lo");

    // DIVU 7 / 2
    run_op(MULDIV_DIVU, 32'h7, 32'h2, 10, MULDIV_NOTHING, 32'hFFFF_FFFF, "divu");
    rd(1'b1, 32'h1, "divu_hi");
    rd(1'b0, 32'h3, "divu_lo");

    // DIV overflow corner
    run_op(MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, MULDIV_NOTHING, 32'h1, "div_ovf");
    rd(1'b1, 32'h0, "div_ovf_hi");
    rd(1'b0, 32'h8000_0000, "div_ovf_lo");

    // MTHI / MTLO: no same-cycle bypass, visible next cycle, never busy
    step(1'b0, MULDIV_MTHI, 32'h1234_5678, 32'h0, 1'b1, "mthi_issue", 1, 32'h0, 1, 1'b0, 1, 1'b0);
    rd(1'b1, 32'h1234_5678, "mthi_hi");
    step(1'b0, MULDIV_MTLO, 32'hCAFE_F00D, 32'h0, 1'b0, "mtlo_issue", 1, 32'h8000_0000, 1, 1'b0, 1, 1'b0);
    rd(1'b0, 32'hCAFE_F00D, "mtlo_lo");

    // Divide by zero leaves HI/LO untouched
    run_op(MULDIV_DIV, 32'd100, 32'h0, 10, MULDIV_NOTHING, 32'h1234_5678, "div0");
    rd(1'b1, 32'h1234_5678, "div0_hi");
    rd(1'b0, 32'hCAFE_F00D, "div0_lo");

    // Back-to-back: MULT held during DIVU busy is ignored, then accepted
    run_op(MULDIV_DIVU, 32'd100, 32'd7, 10, MULDIV_MULT, 32'h1234_5678, "divu_hold");
    run_op(MULDIV_MULT, 32'h0001_0000, 32'h0001_0000, 5, MULDIV_NOTHING, 32'h2, "mult_b2b");
    rd(1'b1, 32'h1, "mult_b2b_hi");
    rd(1'b0, 32'h0, "mult_b2b_lo");

    // Reset in the 3rd busy cycle discards the pending result
    step(1'b0, MULDIV_MULT, 32'h5, 32'h6, 1'b1, "rmid_start", 1, 32'h1, 1, 1'b1, 1, 1'b0);
    step(1'b0, MULDIV_NOTHING, 32'h0, 32'h0, 1'b1, "rmid_busy1", 1, 32'h1, 1, 1'b0, 1, 1'b1);
    step(1'b0, MULDIV_NOTHING, 32'h0, 32'h0, 1'b1, "rmid_busy2", 1, 32'h1, 1, 1'b0, 1, 1'b1);
    step(1'b1, MULDIV_NOTHING, 32'h0, 32'h0, 1'b1, "rmid_rst_hi", 1, 32'h0, 1, 1'b0, 1, 1'b0);
    step(1'b1, MULDIV_NOTHING, 32'h0, 32'h0, 1'b0, "rmid_rst_lo", 1, 32'h0, 1, 1'b0, 1, 1'b0);
    idle(8);
    rd(1'b1, 32'h0, "rmid_late_hi");
    rd(1'b0, 32'h0, "rmid_late_lo");

    idle(3);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
